stream_rr_arbiter: RTL and testbench
====================================

Name: stream_rr_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit valid/ready data path among NUM_REQ requesters at packet granularity.
- Once a requester is granted, it holds the path until it sends a beat with last=1, or until the MAX_BEATS watchdog forces release.
- Output is fully registered and drives the shared consumer's data_in/valid interface.
- Sits between the upstream producers and the single datapath instance.

Parameters:
- WIDTH, 32, data beat width in bits (the project DATA_WIDTH define, 32).
- NUM_REQ, 4, number of requesters, 2..16.
- MAX_BEATS, 256, watchdog limit on beats per packet, >=1.
- IDW, $clog2(NUM_REQ), width of the requester id.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  NUM_REQ  per-requester beat valid.
- in_last  input  NUM_REQ  per-requester last-beat flag.
- in_data  input  NUM_REQ*WIDTH  packed beats; requester i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NUM_REQ  per-requester accept.
- out_valid  output  1  registered beat valid.
- out_data  output  WIDTH  registered beat.
- out_last  output  1  registered last flag.
- out_id  output  IDW  source requester of the current beat.
- out_ready  input  1  consumer accept.
- busy  output  1  high while a grant is held.
- wdog_err  output  1  one-cycle pulse on forced release.

Behaviour:
- Reset: asynchronous assertion, synchronous deassertion handled externally.
  - Reset values: all outputs 0; state=IDLE; rr pointer=0; beat counter=0; grant id=0.
  - Reset mid-packet drops the in-flight beat and the grant with no recovery.
- Interface rule: clock is clk, reset is rst_n; reset is asynchronous active-low.
- Transfer definitions:
  - Output transfer: out_valid && out_ready.
  - Input transfer on requester i: in_valid[i] && in_ready[i].
- Slot free: slot_free = !out_valid || out_ready. This is a combinational path from out_ready to in_ready; no other combinational input-to-output paths are allowed.
- State IDLE:
  - in_ready = 0, busy = 0.
  - If any in_valid is set: winner = first set bit searching ptr, ptr+1, ... mod NUM_REQ. Register grant=winner, clear beat counter, go to GRANT.
  - Arbitration costs exactly one cycle.
- State GRANT:
  - busy = 1.
  - in_ready[grant] = slot_free; all other in_ready bits are 0.
  - On input transfer: capture out_data, out_last, out_id=grant; set out_valid=1; increment beat counter.
  - Release when the accepted beat has in_last=1: ptr=(grant+1) mod NUM_REQ; go to IDLE.
  - Watchdog release when the accepted beat is beat number MAX_BEATS and in_last=0:
    - forward the beat unchanged;
    - pulse wdog_err for one cycle;
    - apply the same ptr update and return to IDLE.
  - The remaining beats from that requester are arbitrated as a new packet.
- Output register:
  - If slot_free and there is no input transfer, out_valid is cleared.
  - While out_valid=1 and out_ready=0, out_data, out_last and out_id are held stable.
- Latency:
  - in_valid rising in IDLE at cycle 0 -> in_ready at cycle 1 -> out_valid at cycle 2.
  - Sustained throughput inside a packet is 1 beat/cycle.
  - Single-beat packets achieve 1 beat per 2 cycles.
- Fairness: the just-served requester has the lowest priority next round. A requester that is continuously valid waits at most NUM_REQ-1 packets.
- Boundary conditions:
  - A granted requester that drops in_valid mid-packet keeps the grant; there is no timeout on idle cycles.
  - in_valid on non-granted requesters is ignored until IDLE.
  - ptr wraps from NUM_REQ-1 to 0.
  - The beat counter saturates logic at MAX_BEATS and never wraps.
  - MAX_BEATS=1 forces release after every beat; wdog_err pulses only if last=0.
- Assertions:
  - in_ready is at most one-hot.
  - out_* are stable while stalled.
  - No input transfer when slot_free=0.

Test Plan:
- Single requester: req0 sends 3 beats 0xA0..0xA2, last on 0xA2, out_ready=1 -> out_valid first at cycle 2; beats are consecutive with out_id=0; out_last only on 0xA2; busy drops after.
- Round-robin: all 4 valid, each sending 1-beat packets continuously -> grant order 0,1,2,3,0,1; a new beat every 2 cycles.
- Backpressure: out_ready=0 for 5 cycles mid-packet -> out_data is held stable; in_ready[grant]=0; no beat lost or duplicated after out_ready=1.
- Watchdog: MAX_BEATS=4; req2 sends 6 beats with no last -> wdog_err pulses with the 4th beat; req1 (waiting) is granted next; req2's remaining 2 beats come after.
- Lock: req1 granted; req0 and req3 assert valid mid-packet -> they get no in_ready until req1's last; next grant goes to req3 (ptr=2).
- Reset mid-packet: assert rst_n=0 during a beat stall -> all outputs go to 0 immediately; after release, arbitration restarts at req0.

Source files
------------

// File: rtl/stream_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one registered valid/ready data path.
// A grant lasts until a last beat or until MAX_BEATS beats force a release.
module stream_rr_arbiter #(
    parameter int WIDTH     = 32,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BEATS = 256,
    parameter int IDW       = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       in_valid,
    input  logic [NUM_REQ-1:0]       in_last,
    input  logic [NUM_REQ*WIDTH-1:0] in_data,
    output logic [NUM_REQ-1:0]       in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_last,
    output logic [IDW-1:0]           out_id,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     wdog_err
);
    localparam int CW = $clog2(MAX_BEATS + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_reg, state_next;
    logic [IDW-1:0]   ptr_reg, ptr_next;
    logic [IDW-1:0]   grant_reg, grant_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             out_valid_reg, out_valid_next;
    logic [WIDTH-1:0] out_data_reg, out_data_next;
    logic             out_last_reg, out_last_next;
    logic [IDW-1:0]   out_id_reg, out_id_next;
    logic             wdog_reg, wdog_next;

    logic [WIDTH-1:0] data_arr [NUM_REQ];
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   release_ptr;
    logic             slot_free;
    logic             in_xfer;

    assign slot_free = !out_valid_reg || out_ready;
    assign in_xfer   = (state_reg == GRANT) && slot_free && in_valid[grant_reg];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign data_arr[gi] = in_data[gi*WIDTH +: WIDTH];
            assign in_ready[gi] = (state_reg == GRANT) && (grant_reg == IDW'(gi)) && slot_free;
        end
    endgenerate

    // First valid requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        logic [IDW:0] idx;
        logic         found;
        winner = ptr_reg;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr_reg} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NUM_REQ)) begin
                idx = idx - (IDW+1)'(NUM_REQ);
            end
            if (!found && in_valid[idx[IDW-1:0]]) begin
                winner = idx[IDW-1:0];
                found  = 1'b1;
            end
        end
    end

    assign release_ptr = (grant_reg == IDW'(NUM_REQ - 1)) ? '0 : grant_reg + IDW'(1);

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        grant_next     = grant_reg;
        cnt_next       = cnt_reg;
        out_valid_next = slot_free ? 1'b0 : out_valid_reg;
        out_data_next  = out_data_reg;
        out_last_next  = out_last_reg;
        out_id_next    = out_id_reg;
        wdog_next      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|in_valid) begin
                    grant_next = winner;
                    cnt_next   = '0;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (in_xfer) begin
                    out_valid_next = 1'b1;
                    out_data_next  = data_arr[grant_reg];
                    out_last_next  = in_last[grant_reg];
                    out_id_next    = grant_reg;
                    cnt_next       = (cnt_reg == CW'(MAX_BEATS)) ? cnt_reg : cnt_reg + CW'(1);
                    if (in_last[grant_reg]) begin
                        ptr_next   = release_ptr;
                        state_next = IDLE;
                    end else if (cnt_reg == CW'(MAX_BEATS - 1)) begin
                        // Beat number MAX_BEATS without last: forward it, then force release.
                        ptr_next   = release_ptr;
                        state_next = IDLE;
                        wdog_next  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            grant_reg     <= '0;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
            out_id_reg    <= '0;
            wdog_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            grant_reg     <= grant_next;
            cnt_reg       <= cnt_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_last_reg  <= out_last_next;
            out_id_reg    <= out_id_next;
            wdog_reg      <= wdog_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;
    assign out_id    = out_id_reg;
    assign busy      = (state_reg == GRANT);
    assign wdog_err  = wdog_reg;

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(in_ready));
    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_last) && $stable(out_id)));
    a_no_xfer_full: assert property (@(posedge clk) disable iff (!rst_n)
        !slot_free |-> ((in_valid & in_ready) == '0));
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scoreboard bench for stream_rr_arbiter: sources feed per-requester queues,
// each scenario pushes the beats it expects in arbitration order.
module tb_stream_rr_arbiter;
    localparam int W    = 32;
    localparam int NREQ = 4;

    typedef struct packed {logic last; logic [W-1:0] data;} src_t;
    typedef struct packed {logic [1:0] id; logic last; logic [W-1:0] data;} beat_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NREQ-1:0] in_valid = '0;
    logic [NREQ-1:0] in_last = '0;
    logic [NREQ*W-1:0] in_data = '0;
    logic [NREQ-1:0] in_ready;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic            out_last;
    logic [1:0]      out_id;
    logic            out_ready = 1'b0;
    logic            busy;
    logic            wdog_err;

    src_t            src_q [NREQ][$];
    beat_t           exp_q [$];
    logic [NREQ-1:0] src_en = '0;
    logic [NREQ-1:0] xfer;
    logic [NREQ-1:0] obs_in_ready;
    logic            obs_valid, obs_busy, obs_wdog, obs_oxfer;
    beat_t           obs_beat, exp_b;
    int              total = 0;
    int              bad = 0;

    stream_rr_arbiter #(.WIDTH(W), .NUM_REQ(NREQ), .MAX_BEATS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_last(in_last), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_id(out_id),
        .out_ready(out_ready), .busy(busy), .wdog_err(wdog_err)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [1:0] id, input logic [W-1:0] d, input logic l);
        src_t s;
        s.last = l;
        s.data = d;
        src_q[id].push_back(s);
    endtask

    task automatic expect_beat(input logic [1:0] id, input logic [W-1:0] d, input logic l);
        beat_t b;
        b.id   = id;
        b.last = l;
        b.data = d;
        exp_q.push_back(b);
    endtask

    // One clock: sample outputs, present source heads, advance sources that transferred.
    task automatic step(input int c);
        logic [1:0]   ii;
        logic [W-1:0] d [NREQ];
        obs_valid = out_valid;
        obs_busy  = busy;
        obs_wdog  = wdog_err;
        obs_beat  = {out_id, out_last, out_data};
        obs_oxfer = out_valid && out_ready;
        for (int i = 0; i < NREQ; i++) begin
            ii = 2'(i);
            d[ii] = '0;
            in_valid[ii] = 1'b0;
            in_last[ii] = 1'b0;
            if (src_en[ii] && src_q[ii].size() > 0) begin
                in_valid[ii] = 1'b1;
                in_last[ii] = src_q[ii][0].last;
                d[ii] = src_q[ii][0].data;
            end
        end
        in_data = {d[3], d[2], d[1], d[0]};
        #1;
        obs_in_ready = in_ready;
        xfer = in_valid & in_ready;
        if (obs_oxfer)
            $display("cycle %0d: beat id=%0d last=%0b data=%h", c, out_id, out_last, out_data);
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            ii = 2'(i);
            if (xfer[ii]) void'(src_q[ii].pop_front());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({out_valid, out_last, out_id, busy, wdog_err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00000", {out_valid, out_last, out_id, busy, wdog_err});
        end
        total++;
        if (out_data !== '0) begin
            bad++;
            $display("FAIL reset_data: got %h want 0", out_data);
        end
        total++;
        if (in_ready !== '0) begin
            bad++;
            $display("FAIL reset_ready: got %b want 0000", in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, out_valid} !== 2'b00) begin
            bad++;
            $display("FAIL reset_idle: got %b want 00", {busy, out_valid});
        end
    endtask

    task automatic test_round_robin();
        int last_c = -1;
        out_ready = 1'b1;
        src_en = 4'b1111;
        send(0, 32'h10, 1'b1); send(0, 32'h11, 1'b1);
        send(1, 32'h20, 1'b1); send(1, 32'h21, 1'b1);
        send(2, 32'h30, 1'b1); send(3, 32'h40, 1'b1);
        expect_beat(0, 32'h10, 1'b1); expect_beat(1, 32'h20, 1'b1);
        expect_beat(2, 32'h30, 1'b1); expect_beat(3, 32'h40, 1'b1);
        expect_beat(0, 32'h11, 1'b1); expect_beat(1, 32'h21, 1'b1);
        for (int c = 0; c < 16; c++) begin
            step(c);
            if (obs_oxfer) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rr_sb: got %h want none", obs_beat);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (obs_beat !== exp_b) begin
                        bad++;
                        $display("FAIL rr_sb: got %h want %h", obs_beat, exp_b);
                    end
                end
                if (last_c >= 0) begin
                    total++;
                    if (c - last_c !== 2) begin
                        bad++;
                        $display("FAIL rr_spacing: got %0d want 2", c - last_c);
                    end
                end
                last_c = c;
            end
        end
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL rr_drain: got %0d left want 0", exp_q.size());
        end
    endtask

    task automatic test_single();
        int first_out = -1;
        out_ready = 1'b1;
        src_en = 4'b0001;
        send(0, 32'hA0, 1'b0); send(0, 32'hA1, 1'b0); send(0, 32'hA2, 1'b1);
        expect_beat(0, 32'hA0, 1'b0); expect_beat(0, 32'hA1, 1'b0); expect_beat(0, 32'hA2, 1'b1);
        for (int c = 0; c < 9; c++) begin
            step(c);
            if (obs_valid && first_out < 0) first_out = c;
            if (c == 1) begin
                total++;
                if (obs_in_ready !== 4'b0001) begin
                    bad++;
                    $display("FAIL single_ready: got %b want 0001", obs_in_ready);
                end
            end
            if (c == 6) begin
                total++;
                if ({obs_busy, obs_valid} !== 2'b00) begin
                    bad++;
                    $display("FAIL single_idle: got %b want 00", {obs_busy, obs_valid});
                end
            end
            if (obs_oxfer) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL single_sb: got %h want none", obs_beat);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (obs_beat !== exp_b) begin
                        bad++;
                        $display("FAIL single_sb: got %h want %h", obs_beat, exp_b);
                    end
                end
            end
        end
        total++;
        if (first_out !== 2) begin
            bad++;
            $display("FAIL single_latency: got %0d want 2", first_out);
        end
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL single_drain: got %0d left want 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        beat_t held = '0;
        src_en = 4'b0010;
        send(1, 32'hC0, 1'b0); send(1, 32'hC1, 1'b0); send(1, 32'hC2, 1'b0); send(1, 32'hC3, 1'b1);
        expect_beat(1, 32'hC0, 1'b0); expect_beat(1, 32'hC1, 1'b0);
        expect_beat(1, 32'hC2, 1'b0); expect_beat(1, 32'hC3, 1'b1);
        for (int c = 0; c < 15; c++) begin
            out_ready = (c < 4 || c >= 9);
            step(c);
            if (c == 4) held = obs_beat;
            if (c >= 5 && c <= 9) begin
                total++;
                if ({obs_valid, obs_beat} !== {1'b1, held}) begin
                    bad++;
                    $display("FAIL bp_hold: got %h want %h", {obs_valid, obs_beat}, {1'b1, held});
                end
            end
            if (c >= 4 && c <= 8) begin
                total++;
                if (obs_in_ready[1] !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_ready: got %b want 0", obs_in_ready[1]);
                end
            end
            total++;
            if (obs_wdog !== 1'b0) begin
                bad++;
                $display("FAIL bp_wdog: got %b want 0", obs_wdog);
            end
            if (obs_oxfer) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL bp_sb: got %h want none", obs_beat);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (obs_beat !== exp_b) begin
                        bad++;
                        $display("FAIL bp_sb: got %h want %h", obs_beat, exp_b);
                    end
                end
            end
        end
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL bp_drain: got %0d left want 0", exp_q.size());
        end
    endtask

    task automatic test_watchdog();
        int    wd_cnt = 0;
        beat_t wd_beat;
        out_ready = 1'b1;
        src_en = 4'b0110;
        for (int k = 0; k < 6; k++) send(2, 32'h60 + W'(k), k == 5);
        send(1, 32'h51, 1'b1);
        for (int k = 0; k < 4; k++) expect_beat(2, 32'h60 + W'(k), 1'b0);
        expect_beat(1, 32'h51, 1'b1);
        expect_beat(2, 32'h64, 1'b0); expect_beat(2, 32'h65, 1'b1);
        wd_beat = {2'd2, 1'b0, 32'h63};
        for (int c = 0; c < 14; c++) begin
            step(c);
            if (obs_wdog) begin
                wd_cnt++;
                total++;
                if ({obs_valid, obs_beat} !== {1'b1, wd_beat}) begin
                    bad++;
                    $display("FAIL wdog_beat: got %h want %h", {obs_valid, obs_beat}, {1'b1, wd_beat});
                end
            end
            if (obs_oxfer) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL wdog_sb: got %h want none", obs_beat);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (obs_beat !== exp_b) begin
                        bad++;
                        $display("FAIL wdog_sb: got %h want %h", obs_beat, exp_b);
                    end
                end
            end
        end
        total++;
        if (wd_cnt !== 1) begin
            bad++;
            $display("FAIL wdog_pulses: got %0d want 1", wd_cnt);
        end
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL wdog_drain: got %0d left want 0", exp_q.size());
        end
    endtask

    task automatic test_lock();
        out_ready = 1'b1;
        send(1, 32'h70, 1'b0); send(1, 32'h71, 1'b0); send(1, 32'h72, 1'b1);
        send(0, 32'h80, 1'b1); send(3, 32'h90, 1'b1);
        expect_beat(1, 32'h70, 1'b0); expect_beat(1, 32'h71, 1'b0); expect_beat(1, 32'h72, 1'b1);
        expect_beat(3, 32'h90, 1'b1); expect_beat(0, 32'h80, 1'b1);
        for (int c = 0; c < 14; c++) begin
            src_en = {c >= 2, 1'b0, !(c == 3 || c == 4), c >= 2};
            step(c);
            if (c >= 2 && c <= 5) begin
                total++;
                if ((obs_in_ready & 4'b1001) !== 4'b0000) begin
                    bad++;
                    $display("FAIL lock_ready: got %b want 0xx0 zero on 0/3", obs_in_ready);
                end
            end
            if (c == 4) begin
                total++;
                if (obs_busy !== 1'b1) begin
                    bad++;
                    $display("FAIL lock_hold: got %b want 1", obs_busy);
                end
            end
            if (obs_oxfer) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL lock_sb: got %h want none", obs_beat);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (obs_beat !== exp_b) begin
                        bad++;
                        $display("FAIL lock_sb: got %h want %h", obs_beat, exp_b);
                    end
                end
            end
        end
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL lock_drain: got %0d left want 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        src_en = 4'b0010;
        send(1, 32'hD0, 1'b0); send(1, 32'hD1, 1'b0); send(1, 32'hD2, 1'b1);
        expect_beat(1, 32'hD0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            out_ready = (c < 3);
            step(c);
            if (obs_oxfer) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rmid_sb: got %h want none", obs_beat);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (obs_beat !== exp_b) begin
                        bad++;
                        $display("FAIL rmid_sb: got %h want %h", obs_beat, exp_b);
                    end
                end
            end
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, out_last, out_id, busy, wdog_err} !== 5'b0) begin
            bad++;
            $display("FAIL rmid_flags: got %b want 00000", {out_valid, out_last, out_id, busy, wdog_err});
        end
        total++;
        if (out_data !== '0) begin
            bad++;
            $display("FAIL rmid_data: got %h want 0", out_data);
        end
        src_q[1].delete();
        exp_q.delete();
        src_en = '0;
        in_valid = '0;
        in_last = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        src_en = 4'b0101;
        send(0, 32'hE0, 1'b1); send(2, 32'hE2, 1'b1);
        expect_beat(0, 32'hE0, 1'b1); expect_beat(2, 32'hE2, 1'b1);
        for (int c = 0; c < 8; c++) begin
            step(c);
            if (obs_oxfer) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rmid_restart: got %h want none", obs_beat);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (obs_beat !== exp_b) begin
                        bad++;
                        $display("FAIL rmid_restart: got %h want %h", obs_beat, exp_b);
                    end
                end
            end
        end
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL rmid_drain: got %0d left want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_watchdog();
        test_lock();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
